// File: rtl/seq_divider.sv
// seq_divider: sequential restoring divider that produces one quotient bit
// per clock. It sits beside the shift-add sequential multiplier and uses the
// same start/done handshake toward the control FSM.
//
// Divide-by-zero skips the iteration loop entirely. It returns an all-ones
// quotient, the low bits of the dividend as the remainder, and raises
// div_by_zero.
//
// state | meaning
// ------+----------------------------------------------
// IDLE  | waiting for start; operands are latched here
// RUN   | iterating, one quotient bit per clock
// DONE  | results valid; done pulses for one cycle
//
// Ports:
//   clk         rising-edge clock
//   reset       synchronous, active-high reset
//   start       one-cycle request, sampled only in IDLE
//   dividend    unsigned dividend, sampled with start
//   divisor     unsigned divisor, sampled with start
//   quotient    registered quotient
//   remainder   registered remainder
//   busy        high while iterating
//   done        one-cycle pulse when the results update
//   div_by_zero registered flag for the last operation

module seq_divider #(
    parameter int DVD_W = 16,
    parameter int DVS_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [DVD_W-1:0] dividend,
    input  logic [DVS_W-1:0] divisor,
    output logic [DVD_W-1:0] quotient,
    output logic [DVS_W-1:0] remainder,
    output logic             busy,
    output logic             done,
    output logic             div_by_zero
);

    localparam int               CNT_W     = $clog2(DVD_W) + 1;
    localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(DVD_W - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state, state_nxt;

    logic [DVD_W-1:0] q_sr;
    logic [DVS_W-1:0] d_reg;
    logic [DVS_W:0]   r_reg;
    logic [CNT_W-1:0] cnt;

    logic [DVS_W:0]   trial;
    logic             trial_ge;
    logic [DVS_W:0]   r_nxt;
    logic [DVD_W-1:0] q_nxt;
    logic             last_iter;

    // Trial subtraction is one bit wider than the divisor, so the shifted-in
    // partial remainder never overflows. After each step r_reg < d_reg holds.
    always_comb begin
        trial    = {r_reg[DVS_W-1:0], q_sr[DVD_W-1]};
        trial_ge = (trial >= {1'b0, d_reg});
        r_nxt    = trial_ge ? (trial - {1'b0, d_reg}) : trial;
        q_nxt    = {q_sr[DVD_W-2:0], trial_ge};
    end

    assign last_iter = (cnt == LAST_ITER);

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = (divisor == '0) ? DONE : RUN;
                end
            end
            RUN: begin
                if (last_iter) begin
                    state_nxt = DONE;
                end
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            q_sr        <= '0;
            d_reg       <= '0;
            r_reg       <= '0;
            cnt         <= '0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        if (divisor == '0) begin
                            quotient    <= '1;
                            remainder   <= dividend[DVS_W-1:0];
                            div_by_zero <= 1'b1;
                        end else begin
                            q_sr  <= dividend;
                            d_reg <= divisor;
                            r_reg <= '0;
                            cnt   <= '0;
                        end
                    end
                end
                RUN: begin
                    q_sr  <= q_nxt;
                    r_reg <= r_nxt;
                    cnt   <= cnt + 1'b1;
                    // Publish directly from the last iteration so the results
                    // are valid in the same cycle that done is high.
                    if (last_iter) begin
                        quotient    <= q_nxt;
                        remainder   <= r_nxt[DVS_W-1:0];
                        div_by_zero <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy = (state == RUN);
    assign done = (state == DONE);

endmodule
